maoin_pio_in_capture: RTL and testbench
=======================================

Name: maoin_pio_in_capture

Overview:
- Parametrised multi-bit input PIO: Avalon-MM slave with per-bit synchroniser, optional per-bit debounce, and runtime-selectable edge detection.
- Per-bit sticky edge-capture register and masked level interrupt output.
- Next-generation replacement for the single-bit edge-capture input PIO: pushbuttons and switches on the Nios II system bus.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flops per bit (2..4).
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before the debounced value changes; 0 = bypass (1..65535 otherwise).
- EDGE_RESET, 0, reset value of the EDGE_MODE register (0 rising, 1 falling, 2 any, 3 none).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write happens when chipselect && !write_n.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt = |(edge_capture & irq_mask).

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Register map:
  - 0 DATA (RO): debounced value; writes ignored.
  - 1 EDGE_MODE (RW, bits[1:0]): upper bits read 0.
  - 2 IRQ_MASK (RW, bits[WIDTH-1:0]).
  - 3 EDGE_CAPTURE (R/W1C, bits[WIDTH-1:0]).
- Write bits above WIDTH are ignored; reads zero-extend to 32 bits.
- Reset (reset high at a clk edge):
  - sync chain, debounced value, previous-value register, debounce counters, IRQ_MASK, EDGE_CAPTURE and readdata all go to 0.
  - EDGE_MODE goes to EDGE_RESET.
  - arm counter is loaded with SYNC_STAGES+DEBOUNCE_CYCLES+1.
  - irq = 0.
- Reset mid-debounce discards partial counts. Reset mid-write: reset wins.
- Read path:
  - readdata <= mux(address) every cycle, independent of chipselect; 1-cycle latency.
  - A read of EDGE_CAPTURE has no side effect.
- Synchroniser: SYNC_STAGES flops per bit; sync_out is the last stage.
- Debounce, per bit:
  - DEBOUNCE_CYCLES=0: deb = sync_out (combinational).
  - Otherwise a 16-bit counter cnt. If sync_out == deb, cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: deb <= sync_out and cnt <= 0; otherwise cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes deb.
- Edge detect:
  - prev <= deb every cycle.
  - rise = deb & ~prev; fall = ~deb & prev.
  - det = rise / fall / rise|fall / 0, per EDGE_MODE.
- Arm:
  - The counter decrements to 0 after reset.
  - While it is nonzero, det is forced to 0, so inputs already high at reset create no capture.
  - prev still tracks deb during this time.
- Capture, per bit i:
  - If det[i]: cap[i] <= 1.
  - Else if a write to addr 3 has writedata[i]=1: cap[i] <= 0.
  - Otherwise hold.
  - When a clear and a new edge coincide on the same bit, the edge wins (no lost event).
  - Clearing one bit does not affect the others.
- Latency:
  - A step on in_port stable before clk edge 1 sets cap on edge SYNC_STAGES+1 (bypass) or SYNC_STAGES+DEBOUNCE_CYCLES+1 (debounce).
  - irq asserts in the same cycle cap sets (if the bit is masked in).
  - cap is visible on readdata one cycle after address=3 is presented.
- Register writes:
  - An EDGE_MODE write takes effect for det on the following cycle and never generates an edge itself.
  - An IRQ_MASK write changes irq combinationally from the next cycle; a pending capture with a newly set mask bit raises irq immediately.

Test Plan:
- Reset/arm: WIDTH=8, SYNC=2, DEB=0, in_port=8'hFF held through reset -> after release cap=0, irq=0; read addr 0 returns 32'h000000FF after the arm window.
- Rising capture and latency: mask=8'h01, in_port[0] 0->1 before edge 1 -> cap[0]=1 and irq=1 after edge 3; read addr 3 -> 32'h00000001; write 1 to addr 3 -> cap=0, irq=0 next cycle.
- Modes:
  - EDGE_MODE=1: pulse in_port[3] 1->0->1 -> only the fall sets cap[3].
  - EDGE_MODE=2: both transitions set cap[3], cleared between.
  - EDGE_MODE=3: no capture.
- Debounce: DEB=4; 3-cycle glitch on in_port[2] -> deb and cap unchanged; 4-cycle-stable step -> cap[2] sets exactly 2+4+1 edges after the step.
- Simultaneous clear and edge: a write of 8'h10 to addr 3 in the same cycle det[4]=1 -> cap[4] stays 1. A write of 8'h20 clears only bit 5.
- Mask and width: write 32'hFFFFFFFF to addr 2 -> readback 32'h000000FF. Mask set after a pending capture -> irq rises next cycle. Reset asserted mid-debounce -> counters clear, no capture.

Source files
------------

// File: rtl/maoin_pio_in_capture.sv
// Multi-bit input PIO on Avalon-MM: per-bit synchroniser, optional debounce, selectable
// edge detection, sticky write-1-to-clear capture and a masked level interrupt.
module maoin_pio_in_capture #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_RESET      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] AddrData    = 2'd0;
  localparam logic [1:0] AddrEdgeMode = 2'd1;
  localparam logic [1:0] AddrIrqMask = 2'd2;
  localparam logic [1:0] AddrCapture = 2'd3;

  localparam logic [1:0] ModeRise = 2'd0;
  localparam logic [1:0] ModeFall = 2'd1;
  localparam logic [1:0] ModeAny  = 2'd2;

  localparam int unsigned   ArmLoad = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam int unsigned   ArmW    = $clog2(ArmLoad + 1);
  localparam logic [ArmW-1:0] ArmInit = ArmW'(ArmLoad);

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] deb;

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign deb = sync_out;
  end else begin : g_debounce
    localparam logic [15:0] CntLast = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      cnt_q [WIDTH];
    logic [15:0]      cnt_d [WIDTH];
    logic [WIDTH-1:0] deb_q, deb_d;

    // A bit's counter only runs while its synchronised input disagrees with
    // the debounced value; any agreement restarts the count.
    always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = '0;
        if (sync_out[i] != deb_q[i]) begin
          if (cnt_q[i] == CntLast) begin
            deb_d[i] = sync_out[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 16'd1;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        deb_q <= '0;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        deb_q <= deb_d;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end

    assign deb = deb_q;
  end

  // ---------------------------------------------------------------------------
  // Edge detection, arm window and capture
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] prev_q;
  logic [ArmW-1:0]  arm_q, arm_d;
  logic [1:0]       edge_mode_q, edge_mode_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      readdata_d;
  logic [WIDTH-1:0] rise, fall, det, clr;
  logic             wr_en;

  assign wr_en = chipselect && !write_n;
  assign rise  = deb & ~prev_q;
  assign fall  = ~deb & prev_q;
  assign arm_d = (arm_q != '0) ? arm_q - ArmW'(1) : arm_q;

  // Detection is held off until the pipeline has flushed after reset, so
  // inputs already asserted at reset do not register as edges.
  always_comb begin
    det = '0;
    if (arm_q == '0) begin
      case (edge_mode_q)
        ModeRise: det = rise;
        ModeFall: det = fall;
        ModeAny:  det = rise | fall;
        default:  det = '0;
      endcase
    end
  end

  // A new edge wins over a simultaneous write-1-to-clear on the same bit.
  assign clr   = (wr_en && address == AddrCapture) ? writedata[WIDTH-1:0] : '0;
  assign cap_d = det | (cap_q & ~clr);

  always_comb begin
    edge_mode_d = edge_mode_q;
    irq_mask_d  = irq_mask_q;
    if (wr_en && address == AddrEdgeMode) begin
      edge_mode_d = writedata[1:0];
    end
    if (wr_en && address == AddrIrqMask) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      AddrData:     readdata_d = 32'(deb);
      AddrEdgeMode: readdata_d = 32'(edge_mode_q);
      AddrIrqMask:  readdata_d = 32'(irq_mask_q);
      default:      readdata_d = 32'(cap_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q      <= '0;
      arm_q       <= ArmInit;
      edge_mode_q <= 2'(EDGE_RESET);
      irq_mask_q  <= '0;
      cap_q       <= '0;
      readdata    <= '0;
    end else begin
      prev_q      <= deb;
      arm_q       <= arm_d;
      edge_mode_q <= edge_mode_d;
      irq_mask_q  <= irq_mask_d;
      cap_q       <= cap_d;
      readdata    <= readdata_d;
    end
  end

  assign irq = |(cap_q & irq_mask_q);

endmodule

// File: tb/tb_maoin_pio_in_capture.sv
// Directed bench: one bypass instance (DEBOUNCE_CYCLES=0) and one debounced
// instance (DEBOUNCE_CYCLES=4) sharing the clock and register bus.
module tb_maoin_pio_in_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in0 = '0;
  logic [7:0]  in4 = '0;
  logic [31:0] readdata0, readdata4;
  logic        irq0, irq4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  maoin_pio_in_capture #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_RESET(0)
  ) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(readdata0), .irq(irq0)
  );

  maoin_pio_in_capture #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_RESET(0)
  ) dut4 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in4),
    .readdata(readdata4), .irq(irq4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  task automatic test_reset();
    in0 = 8'hFF;
    in4 = 8'h00;
    reset = 1'b1;
    address = 2'd3;
    tick();
    tick();
    checks++;
    if (readdata0 !== 32'h0 || irq0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state readdata=%h irq=%b expected 00000000/0", readdata0, irq0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (irq0 !== 1'b0) begin
        failures++;
        $display("FAIL arm_irq cycle=%0d irq=%b expected 0", k, irq0);
      end
    end
    rd(2'd3);
    checks++;
    if (readdata0 !== 32'h0) begin
      failures++;
      $display("FAIL arm_cap got=%h expected 00000000", readdata0);
    end
    rd(2'd0);
    checks++;
    if (readdata0 !== 32'h000000FF) begin
      failures++;
      $display("FAIL arm_data got=%h expected 000000ff", readdata0);
    end
    rd(2'd1);
    checks++;
    if (readdata0 !== 32'h0) begin
      failures++;
      $display("FAIL reset_edge_mode got=%h expected 00000000", readdata0);
    end
    rd(2'd2);
    checks++;
    if (readdata0 !== 32'h0) begin
      failures++;
      $display("FAIL reset_mask got=%h expected 00000000", readdata0);
    end
    in0 = 8'h00;
    repeat (5) tick();
  endtask

  task automatic test_rise();
    logic [2:0] exp_irq;
    exp_irq = 3'b100;
    wr(2'd2, 32'h1);
    address = 2'd3;
    in0 = 8'h01;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (irq0 !== exp_irq[k-1]) begin
        failures++;
        $display("FAIL rise_latency edge=%0d irq=%b expected %b", k, irq0, exp_irq[k-1]);
      end
    end
    tick();
    checks++;
    if (readdata0 !== 32'h1) begin
      failures++;
      $display("FAIL rise_cap got=%h expected 00000001", readdata0);
    end
    wr(2'd3, 32'h1);
    checks++;
    if (irq0 !== 1'b0) begin
      failures++;
      $display("FAIL w1c_irq irq=%b expected 0", irq0);
    end
    rd(2'd3);
    checks++;
    if (readdata0 !== 32'h0) begin
      failures++;
      $display("FAIL w1c_cap got=%h expected 00000000", readdata0);
    end
  endtask

  task automatic test_modes();
    wr(2'd1, 32'h1);
    rd(2'd1);
    checks++;
    if (readdata0 !== 32'h1) begin
      failures++;
      $display("FAIL mode_readback got=%h expected 00000001", readdata0);
    end
    in0 = 8'h09;
    repeat (4) tick();
    rd(2'd3);
    checks++;
    if (readdata0 !== 32'h0) begin
      failures++;
      $display("FAIL fall_mode_rise got=%h expected 00000000", readdata0);
    end
    in0 = 8'h01;
    repeat (4) tick();
    rd(2'd3);
    checks++;
    if (readdata0 !== 32'h8) begin
      failures++;
      $display("FAIL fall_mode_fall got=%h expected 00000008", readdata0);
    end
    in0 = 8'h09;
    repeat (4) tick();
    rd(2'd3);
    checks++;
    if (readdata0 !== 32'h8) begin
      failures++;
      $display("FAIL fall_mode_sticky got=%h expected 00000008", readdata0);
    end
    wr(2'd3, 32'h8);
    wr(2'd1, 32'h2);
    in0 = 8'h01;
    repeat (4) tick();
    rd(2'd3);
    checks++;
    if (readdata0 !== 32'h8) begin
      failures++;
      $display("FAIL any_mode_fall got=%h expected 00000008", readdata0);
    end
    wr(2'd3, 32'h8);
    in0 = 8'h09;
    repeat (4) tick();
    rd(2'd3);
    checks++;
    if (readdata0 !== 32'h8) begin
      failures++;
      $display("FAIL any_mode_rise got=%h expected 00000008", readdata0);
    end
    wr(2'd3, 32'h8);
    wr(2'd1, 32'h3);
    in0 = 8'h01;
    repeat (4) tick();
    in0 = 8'h09;
    repeat (4) tick();
    rd(2'd3);
    checks++;
    if (readdata0 !== 32'h0) begin
      failures++;
      $display("FAIL none_mode got=%h expected 00000000", readdata0);
    end
    wr(2'd1, 32'h0);
  endtask

  task automatic test_back_to_back();
    in0 = 8'h19;
    tick();
    tick();
    wr(2'd3, 32'h10);
    rd(2'd3);
    checks++;
    if (readdata0 !== 32'h10) begin
      failures++;
      $display("FAIL clear_vs_edge got=%h expected 00000010", readdata0);
    end
    in0 = 8'h39;
    repeat (4) tick();
    rd(2'd3);
    checks++;
    if (readdata0 !== 32'h30) begin
      failures++;
      $display("FAIL two_caps got=%h expected 00000030", readdata0);
    end
    wr(2'd3, 32'h20);
    rd(2'd3);
    checks++;
    if (readdata0 !== 32'h10) begin
      failures++;
      $display("FAIL clear_one_bit got=%h expected 00000010", readdata0);
    end
  endtask

  task automatic test_mask();
    wr(2'd2, 32'h0);
    checks++;
    if (irq0 !== 1'b0) begin
      failures++;
      $display("FAIL mask_off irq=%b expected 0", irq0);
    end
    wr(2'd2, 32'h10);
    checks++;
    if (irq0 !== 1'b1) begin
      failures++;
      $display("FAIL mask_late irq=%b expected 1", irq0);
    end
    wr(2'd2, 32'hFFFFFFFF);
    rd(2'd2);
    checks++;
    if (readdata0 !== 32'h000000FF) begin
      failures++;
      $display("FAIL mask_width got=%h expected 000000ff", readdata0);
    end
    wr(2'd1, 32'hFFFFFFFF);
    rd(2'd1);
    checks++;
    if (readdata0 !== 32'h3) begin
      failures++;
      $display("FAIL mode_width got=%h expected 00000003", readdata0);
    end
    wr(2'd1, 32'h0);
    wr(2'd0, 32'hFFFFFFFF);
    rd(2'd0);
    checks++;
    if (readdata0 !== 32'h39) begin
      failures++;
      $display("FAIL data_ro got=%h expected 00000039", readdata0);
    end
    wr(2'd3, 32'hFF);
    rd(2'd3);
    checks++;
    if (readdata0 !== 32'h0 || irq0 !== 1'b0) begin
      failures++;
      $display("FAIL clear_all cap=%h irq=%b expected 00000000/0", readdata0, irq0);
    end
  endtask

  task automatic test_debounce();
    wr(2'd2, 32'h4);
    in4 = 8'h04;
    repeat (3) tick();
    in4 = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (irq4 !== 1'b0) begin
        failures++;
        $display("FAIL glitch_irq cycle=%0d irq=%b expected 0", k, irq4);
      end
    end
    rd(2'd0);
    checks++;
    if (readdata4 !== 32'h0) begin
      failures++;
      $display("FAIL glitch_deb got=%h expected 00000000", readdata4);
    end
    in4 = 8'h04;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (irq4 !== (k == 7)) begin
        failures++;
        $display("FAIL deb_latency edge=%0d irq=%b expected %b", k, irq4, (k == 7));
      end
    end
    rd(2'd3);
    checks++;
    if (readdata4 !== 32'h4) begin
      failures++;
      $display("FAIL deb_cap got=%h expected 00000004", readdata4);
    end
    rd(2'd0);
    checks++;
    if (readdata4 !== 32'h4) begin
      failures++;
      $display("FAIL deb_data got=%h expected 00000004", readdata4);
    end
  endtask

  task automatic test_reset_mid_debounce();
    in4 = 8'h00;
    repeat (10) tick();
    wr(2'd3, 32'h4);
    in4 = 8'h04;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    address = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (readdata4 !== ((k == 7) ? 32'h4 : 32'h0)) begin
        failures++;
        $display("FAIL post_reset_deb edge=%0d got=%h expected %h", k, readdata4,
                 ((k == 7) ? 32'h4 : 32'h0));
      end
    end
    repeat (8) tick();
    rd(2'd3);
    checks++;
    if (readdata4 !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_cap got=%h expected 00000000", readdata4);
    end
    rd(2'd2);
    checks++;
    if (readdata4 !== 32'h0 || irq4 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_mask got=%h irq=%b expected 00000000/0", readdata4, irq4);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_modes();
    test_back_to_back();
    test_mask();
    test_debounce();
    test_reset_mid_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
